farbborg_scan: RTL and testbench

- Display scan engine that sits directly downstream of the wb_farbborg frame buffer and drives the LED cube pins (gpio_0 lsr_*/psr_*/latch_data).
- Reads 8-bit brightness values from the frame-buffer read port and performs per-step PWM comparison.
- Loads the column latches one 8-bit group at a time, then steps the plane shift register.
- Emits a frame_done pulse so the Wishbone side can swap buffers.

---
 rtl/farbborg_pkg.sv | 27 ++
 rtl/farbborg_scan_if.sv | 13 +
 rtl/farbborg_byte_fetch.sv | 60 ++++++
 rtl/farbborg_scan.sv | 167 ++++++++++++++++
 tb/tb_farbborg_scan.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/farbborg_pkg.sv
// Shared types and constants for the farbborg LED-cube scan engine.
package farbborg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PSH_SETUP,
        PSH_CLK,
        FETCH,
        LSETUP,
        LCLK
    } state_t;

    localparam int PLANES_DEF      = 5;
    localparam int NUM_LATCHES_DEF = 10;
    localparam int PWM_STEPS_DEF   = 256;
    localparam int ADR_W_DEF       = 9;

    // Eight reads plus one trailing cycle to capture the last read's data.
    localparam int FETCH_LEN    = 9;
    localparam int CH_PER_PLANE = NUM_LATCHES_DEF * 8;

    // Width of a counter or address spanning n values; never zero.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/farbborg_scan_if.sv
// Frame-buffer read port between the scan engine and the wb_farbborg buffer.
interface farbborg_scan_if #(
    parameter int ADR_W = 9
) ();
    // Handshake: mem_dat carries the byte at mem_adr exactly one cycle after
    // a cycle with mem_rd=1; there is no stall, the buffer always answers.
    logic             mem_rd;
    logic [ADR_W-1:0] mem_adr;
    logic [7:0]       mem_dat;

    modport master (output mem_rd, output mem_adr, input mem_dat);
    modport slave  (input mem_rd, input mem_adr, output mem_dat);
endinterface

// File: rtl/farbborg_byte_fetch.sv
// Reads eight consecutive brightness bytes and turns them into one 8-bit
// latch word by comparing each against the current PWM step.
module farbborg_byte_fetch
    import farbborg_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADR_W-1:0] base,
    input  logic [7:0]       step,
    farbborg_scan_if.master  mem,
    output logic             done,
    output logic [7:0]       fetched
);

    localparam logic [3:0] LAST = 4'(FETCH_LEN - 1);

    logic       busy;
    logic [3:0] idx;
    logic [7:0] acc;
    logic       hit;

    // start is a one-cycle request issued the cycle before the first read;
    // done is high for the single cycle in which fetched is complete.
    assign hit  = mem.mem_dat > step;
    assign done = busy && (idx == LAST);

    // Bit 7 arrives in the done cycle, so it bypasses the accumulator.
    always_comb begin
        fetched    = acc;
        fetched[7] = hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            idx         <= '0;
            acc         <= '0;
            mem.mem_rd  <= 1'b0;
            mem.mem_adr <= '0;
        end else if (start) begin
            busy        <= 1'b1;
            idx         <= '0;
            acc         <= '0;
            mem.mem_rd  <= 1'b1;
            mem.mem_adr <= base;
        end else if (busy) begin
            if (idx != '0) begin
                acc[3'(idx - 4'd1)] <= hit;
            end
            idx         <= done ? '0 : idx + 4'd1;
            busy        <= !done;
            mem.mem_rd  <= (idx < 4'd7);
            mem.mem_adr <= (idx < 4'd7) ? mem.mem_adr + ADR_W'(1) : '0;
        end
    end

endmodule

// File: rtl/farbborg_scan.sv
// LED-cube scan engine: walks planes, PWM steps and latch groups, loading
// the column latches and stepping the plane shift register.
module farbborg_scan
    import farbborg_pkg::*;
#(
    parameter int PLANES      = PLANES_DEF,
    parameter int NUM_LATCHES = NUM_LATCHES_DEF,
    parameter int PWM_STEPS   = PWM_STEPS_DEF,
    parameter int ADR_W       = ADR_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    farbborg_scan_if.master mem,
    output logic            lsr_clr,
    output logic            lsr_d,
    output logic            lsr_c,
    output logic [7:0]      latch_data,
    output logic            psr_d,
    output logic            psr_c,
    output logic            frame_done,
    output state_t          dbg_state
);

    localparam int PL_W = cnt_w(PLANES);
    localparam int GR_W = cnt_w(NUM_LATCHES);
    localparam int ST_W = cnt_w(PWM_STEPS);
    localparam int CH   = NUM_LATCHES * 8;

    localparam logic [PL_W-1:0] PLANE_LAST = PL_W'(PLANES - 1);
    localparam logic [GR_W-1:0] GROUP_LAST = GR_W'(NUM_LATCHES - 1);
    localparam logic [ST_W-1:0] STEP_LAST  = ST_W'(PWM_STEPS - 1);

    state_t            state, state_nx;
    logic [PL_W-1:0]   plane, plane_nx;
    logic [GR_W-1:0]   group, group_nx;
    logic [ST_W-1:0]   step, step_nx;
    logic              lsr_clr_nx, lsr_d_nx, lsr_c_nx, psr_d_nx, psr_c_nx, frame_done_nx;
    logic [7:0]        latch_data_nx;
    logic              fetch_start, fetch_done;
    logic [7:0]        fetch_byte;
    logic [ADR_W-1:0]  fetch_base;

    // Base follows the next-cycle counters because start precedes FETCH.
    assign fetch_base = ADR_W'(int'(plane_nx) * CH + int'(group_nx) * 8);
    assign dbg_state  = state;

    farbborg_byte_fetch #(.ADR_W(ADR_W)) u_fetch (
        .clk     (clk),
        .rst_n   (reset_n),
        .start   (fetch_start),
        .base    (fetch_base),
        .step    (8'(step)),
        .mem     (mem),
        .done    (fetch_done),
        .fetched (fetch_byte)
    );

    always_comb begin
        state_nx      = state;
        plane_nx      = plane;
        group_nx      = group;
        step_nx       = step;
        lsr_clr_nx    = lsr_clr;
        lsr_d_nx      = lsr_d;
        latch_data_nx = latch_data;
        psr_d_nx      = psr_d;
        lsr_c_nx      = 1'b0;
        psr_c_nx      = 1'b0;
        frame_done_nx = 1'b0;
        fetch_start   = 1'b0;
        case (state)
            IDLE: begin
                lsr_clr_nx    = 1'b1;
                lsr_d_nx      = 1'b0;
                latch_data_nx = '0;
                psr_d_nx      = 1'b0;
                if (enable) begin
                    state_nx = PSH_SETUP;
                    psr_d_nx = (plane == '0);
                end
            end
            PSH_SETUP: begin
                state_nx = PSH_CLK;
                psr_c_nx = 1'b1;
            end
            PSH_CLK: begin
                state_nx    = FETCH;
                lsr_clr_nx  = 1'b0;
                psr_d_nx    = 1'b0;
                fetch_start = 1'b1;
            end
            FETCH: begin
                if (fetch_done) begin
                    state_nx      = LSETUP;
                    latch_data_nx = fetch_byte;
                    lsr_d_nx      = (group == '0);
                end
            end
            LSETUP: begin
                state_nx = LCLK;
                lsr_c_nx = 1'b1;
            end
            LCLK: begin
                if (group != GROUP_LAST) begin
                    group_nx    = group + GR_W'(1);
                    state_nx    = FETCH;
                    fetch_start = 1'b1;
                end else if (step != STEP_LAST) begin
                    group_nx    = '0;
                    step_nx     = step + ST_W'(1);
                    state_nx    = FETCH;
                    fetch_start = 1'b1;
                end else begin
                    group_nx   = '0;
                    step_nx    = '0;
                    lsr_clr_nx = 1'b1;
                    if (plane == PLANE_LAST) begin
                        plane_nx      = '0;
                        frame_done_nx = 1'b1;
                    end else begin
                        plane_nx = plane + PL_W'(1);
                    end
                    // enable only takes effect here, so planes are never cut short.
                    if (enable) begin
                        state_nx = PSH_SETUP;
                        psr_d_nx = (plane_nx == '0);
                    end else begin
                        state_nx      = IDLE;
                        lsr_d_nx      = 1'b0;
                        latch_data_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            plane      <= '0;
            group      <= '0;
            step       <= '0;
            lsr_clr    <= 1'b1;
            lsr_d      <= 1'b0;
            lsr_c      <= 1'b0;
            latch_data <= '0;
            psr_d      <= 1'b0;
            psr_c      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            plane      <= plane_nx;
            group      <= group_nx;
            step       <= step_nx;
            lsr_clr    <= lsr_clr_nx;
            lsr_d      <= lsr_d_nx;
            lsr_c      <= lsr_c_nx;
            latch_data <= latch_data_nx;
            psr_d      <= psr_d_nx;
            psr_c      <= psr_c_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_farbborg_scan.sv
// Bench for farbborg_scan with a small cube (2 planes, 2 latches, 4 PWM steps).
module tb_farbborg_scan;
    import farbborg_pkg::*;

    localparam int PLANES      = 2;
    localparam int NUM_LATCHES = 2;
    localparam int PWM_STEPS   = 4;
    localparam int ADR_W       = 5;
    localparam int PLANE_CYC   = 2 + 11 * NUM_LATCHES * PWM_STEPS;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       lsr_clr, lsr_d, lsr_c, psr_d, psr_c, frame_done;
    logic [7:0] latch_data;
    state_t     dbg_state;

    logic [7:0] mem [32];
    logic [7:0] pat [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd255};
    logic [7:0] g0_exp [4] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0};

    logic [8:0] exp_q[$];
    logic       psr_q[$];
    logic [8:0] lat_e;
    logic       psr_e;
    int         n_checks = 0;
    int         n_fail = 0;

    farbborg_scan_if #(.ADR_W(ADR_W)) m_if ();

    farbborg_scan #(
        .PLANES(PLANES), .NUM_LATCHES(NUM_LATCHES), .PWM_STEPS(PWM_STEPS), .ADR_W(ADR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mem        (m_if.master),
        .lsr_clr    (lsr_clr),
        .lsr_d      (lsr_d),
        .lsr_c      (lsr_c),
        .latch_data (latch_data),
        .psr_d      (psr_d),
        .psr_c      (psr_c),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // Clock and frame-buffer model: data one cycle after the read strobe.
    always #5 clk = ~clk;

    always @(posedge clk) m_if.mem_dat <= m_if.mem_rd ? mem[m_if.mem_adr] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every latch or plane clock pops one expected entry.
    always @(negedge clk) begin
        if (reset_n && lsr_c) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL latch_extra: got 0x%0h, expected no latch clock", {lsr_d, latch_data});
            end else begin
                lat_e = exp_q.pop_front();
                chk("latch", 32'({lsr_d, latch_data}), 32'(lat_e));
            end
        end
        if (reset_n && psr_c) begin
            if (psr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL psr_extra: got psr_d=%0b, expected no plane clock", psr_d);
            end else begin
                psr_e = psr_q.pop_front();
                chk("psr_token", 32'(psr_d), 32'(psr_e));
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_lsr_clr"}, 32'(lsr_clr), 1);
        chk({tag, "_lsr_d"}, 32'(lsr_d), 0);
        chk({tag, "_lsr_c"}, 32'(lsr_c), 0);
        chk({tag, "_latch_data"}, 32'(latch_data), 0);
        chk({tag, "_psr_d"}, 32'(psr_d), 0);
        chk({tag, "_psr_c"}, 32'(psr_c), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_mem_rd"}, 32'(m_if.mem_rd), 0);
        chk({tag, "_mem_adr"}, 32'(m_if.mem_adr), 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Cycle c of a plane: 0 PSH_SETUP, 1 PSH_CLK, then 11-cycle groups.
    task automatic check_timing(input int c, input int pl, input logic fd);
        int r;
        int g;
        chk("psr_d", 32'(psr_d), 32'(c < 2 && pl == 0));
        chk("psr_c", 32'(psr_c), 32'(c == 1));
        chk("lsr_clr", 32'(lsr_clr), 32'(c < 2));
        chk("frame_done", 32'(frame_done), 32'(fd));
        if (c < 2) begin
            chk("state", 32'(dbg_state), (c == 0) ? 32'(PSH_SETUP) : 32'(PSH_CLK));
            chk("mem_rd", 32'(m_if.mem_rd), 0);
            chk("lsr_c", 32'(lsr_c), 0);
        end else begin
            r = (c - 2) % 11;
            g = ((c - 2) / 11) % NUM_LATCHES;
            chk("mem_rd", 32'(m_if.mem_rd), 32'(r < 8));
            if (r < 8) chk("mem_adr", 32'(m_if.mem_adr), 32'(pl * NUM_LATCHES * 8 + g * 8 + r));
            chk("lsr_c", 32'(lsr_c), 32'(r == 10));
            chk("state", 32'(dbg_state),
                (r < 9) ? 32'(FETCH) : (r == 9) ? 32'(LSETUP) : 32'(LCLK));
        end
    endtask

    task automatic run_planes(input int first_plane, input int n_planes, input int drop_at);
        int pl;
        for (int g = 0; g < n_planes * PLANE_CYC; g++) begin
            @(negedge clk);
            pl = (first_plane + g / PLANE_CYC) % PLANES;
            check_timing(g % PLANE_CYC, pl, g > 0 && (g % PLANE_CYC) == 0 && pl == 0);
            if (g == drop_at) enable = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag, input logic fd, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
            chk({tag, "_lsr_clr"}, 32'(lsr_clr), 1);
            chk({tag, "_mem_rd"}, 32'(m_if.mem_rd), 0);
            chk({tag, "_frame_done"}, 32'(frame_done), 32'((i == 0) ? fd : 1'b0));
        end
    endtask

    task automatic push_plane_const(input logic token);
        psr_q.push_back(token);
        for (int s = 0; s < PWM_STEPS; s++) begin
            exp_q.push_back({1'b1, 8'hFE});
            exp_q.push_back({1'b0, 8'hFE});
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 8'(k * 32);

        // Reset and idle with enable low.
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        check_idle("idle", 1'b0, 100);

        // Two full frames, value k*32 everywhere: every latch word is 0xFE.
        for (int p = 0; p < 2 * PLANES; p++) push_plane_const(p % PLANES == 0);
        enable = 1'b1;
        run_planes(0, 2 * PLANES, 2 * PLANES * PLANE_CYC - 1);
        check_idle("frame_end", 1'b1, 3);

        // Graded pattern on group 0; enable dropped mid-plane.
        for (int k = 0; k < 8; k++) mem[k] = pat[k];
        psr_q.push_back(1'b1);
        for (int s = 0; s < PWM_STEPS; s++) begin
            exp_q.push_back({1'b1, g0_exp[s]});
            exp_q.push_back({1'b0, 8'hFE});
        end
        enable = 1'b1;
        run_planes(0, 1, 20);
        check_idle("mid_stop", 1'b0, 10);

        // Re-enable resumes at plane 1 without a plane token.
        push_plane_const(1'b0);
        enable = 1'b1;
        run_planes(1, 1, 0);
        check_idle("resume_end", 1'b1, 3);

        // Asynchronous reset in the middle of a fetch.
        psr_q.push_back(1'b1);
        enable = 1'b1;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            check_timing(g, 0, 1'b0);
        end
        #1 reset_n = 1'b0;
        #1 chk_reset("rst_async");
        @(negedge clk);
        chk_reset("rst_hold");
        reset_n = 1'b1;
        psr_q.push_back(1'b1);
        exp_q.push_back({1'b1, 8'hFE});
        for (int g = 0; g < 13; g++) begin
            @(negedge clk);
            check_timing(g, 0, 1'b0);
        end
        #1 reset_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("queues_empty", 32'(exp_q.size() + psr_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
